// File: rtl/pipe_result_collector_if.sv
// Drain-side valid/ready stream of the result collector.
interface pipe_result_collector_if #(parameter int N = 10);
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/pipe_result_collector.sv
// Captures genuine results of the 3-stage F pipeline via a valid shift register and buffers them in a FIFO.
// Optional running sum of pushed results: define PIPE_COLLECT_SUM_EN.
module pipe_result_collector #(
  parameter int N     = 10,
  parameter int LAT   = 3,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid,
  input  logic [N-1:0]               f_in,
  pipe_result_collector_if.master    drain,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       clr_ovf
`ifdef PIPE_COLLECT_SUM_EN
  ,
  output logic [N+7:0]               sum_out
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [LAT-1:0] vsh;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [N-1:0]   mem [DEPTH];
  logic           push, pop, wr, drop;

  assign empty           = (count == '0);
  assign full            = (count == CW'(DEPTH));
  assign drain.out_valid = ~empty;
  assign drain.out_data  = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push = vsh[LAT-1];
  assign pop  = drain.out_valid & drain.out_ready;
  assign wr   = push & (~full | pop);
  assign drop = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsh      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      vsh[0] <= op_valid;
      for (int i = 1; i < LAT; i++) vsh[i] <= vsh[i-1];
      if (wr)  wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr) - CW'(pop);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= f_in;
  end

`ifdef PIPE_COLLECT_SUM_EN
  always_ff @(posedge clk) begin
    if (rst)     sum_out <= '0;
    else if (wr) sum_out <= sum_out + (N+8)'(f_in);
  end
`endif
endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed bench: models the F pipeline, drives the collector and checks against hand-computed results.
module tb_pipe_result_collector;
  localparam int N = 10, LAT = 3, DEPTH = 8;

  logic clk = 1'b0, rst = 1'b1, op_valid = 1'b0, clr_ovf = 1'b0;
  logic [N-1:0] a = '0, b = '0, c = '0, d = '0;
  logic [N-1:0] s1_ab, s1_cd, s1_d, s2_s, s2_d, f;
  logic [$clog2(DEPTH):0] count;
  logic full, empty, overflow;
  int checks = 0, failures = 0;
  logic [N-1:0] exq[$];
  logic [N+7:0] exp_sum = '0;
`ifdef PIPE_COLLECT_SUM_EN
  logic [N+7:0] sum_out;
`endif

  pipe_result_collector_if #(.N(N)) ob();

  pipe_result_collector #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .f_in(f), .drain(ob.master),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .clr_ovf(clr_ovf)
`ifdef PIPE_COLLECT_SUM_EN
    , .sum_out(sum_out)
`endif
  );

  always #5 clk = ~clk;

  // Upstream pipeline F = ((A+B)+(C-D))*D, F registered two edges after operand launch.
  always @(posedge clk) begin
    s1_ab <= a + b;
    s1_cd <= c - d;
    s1_d  <= d;
    s2_s  <= s1_ab + s1_cd;
    s2_d  <= s1_d;
    f     <= s2_s * s2_d;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] fm(input int av, input int bv, input int cv, input int dv);
    logic [N-1:0] ta, tb, tc, td, r;
    ta = av[N-1:0]; tb = bv[N-1:0]; tc = cv[N-1:0]; td = dv[N-1:0];
    r = ((ta + tb) + (tc - td)) * td;
    return r;
  endfunction

  task automatic set_op(input int av, input int bv, input int cv, input int dv);
    a = av[N-1:0]; b = bv[N-1:0]; c = cv[N-1:0]; d = dv[N-1:0];
    op_valid = 1'b1;
  endtask

  task automatic exp_push(input logic [N-1:0] v);
    exq.push_back(v);
    exp_sum += (N+8)'(v);
  endtask

  task automatic drain_n(input int n);
    logic [N-1:0] e;
    ob.out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      e = exq.pop_front();
      chk("drain_valid", ob.out_valid, 1);
      chk("drain_data", ob.out_data, e);
      tick();
    end
    ob.out_ready = 1'b0;
  endtask

  initial begin
    ob.out_ready = 1'b0;
    // reset and idle
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_valid", ob.out_valid, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", ob.out_valid, 0);
      chk("idle_count", count, 0);
    end

    // latency: F = (7+8)*2 = 30, pushed on the third edge after launch
    set_op(3, 4, 10, 2);
    exp_push(fm(3, 4, 10, 2));
    tick(); op_valid = 1'b0;
    chk("lat_t0", ob.out_valid, 0);
    tick(); chk("lat_t1", ob.out_valid, 0);
    tick(); chk("lat_t2", ob.out_valid, 0);
    tick();
    chk("lat_valid", ob.out_valid, 1);
    chk("lat_data", ob.out_data, 30);
    chk("lat_count", count, 1);
`ifdef PIPE_COLLECT_SUM_EN
    chk("lat_sum", sum_out, 30);
`endif
    drain_n(1);
    chk("lat_empty", empty, 1);

    // stream 8 results (F = i) and drain
    for (int i = 1; i <= 8; i++) begin
      set_op(i, 0, 1, 1);
      exp_push(fm(i, 0, 1, 1));
      tick();
    end
    op_valid = 1'b0;
    tick(); tick(); tick();
    chk("str_full", full, 1);
    chk("str_count", count, 8);
    chk("str_head", ob.out_data, 1);
    drain_n(8);
    chk("str_empty", empty, 1);
    chk("str_count0", count, 0);

    // overflow: 9th result dropped
    for (int i = 0; i < 9; i++) begin
      set_op(10 + i, 5, 3, 2);
      if (i < 8) exp_push(fm(10 + i, 5, 3, 2));
      tick();
    end
    op_valid = 1'b0;
    tick(); tick(); tick();
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
    // clear coinciding with another drop: set wins
    set_op(1, 1, 1, 1);
    tick(); op_valid = 1'b0;
    tick(); tick();
    clr_ovf = 1'b1;
    tick(); clr_ovf = 1'b0;
    chk("ovf_setwins", overflow, 1);
    chk("ovf_count2", count, 8);
    clr_ovf = 1'b1;
    tick(); clr_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);
    drain_n(8);
    chk("ovf_empty", empty, 1);

    // simultaneous push/pop while full
    for (int cyc = 0; cyc < 17; cyc++) begin
      if (cyc < 14) begin
        set_op(40 + cyc, 0, 2, 2);
        exp_push(fm(40 + cyc, 0, 2, 2));
      end else op_valid = 1'b0;
      if (cyc >= 11) begin
        ob.out_ready = 1'b1;
        chk("sim_data", ob.out_data, exq.pop_front());
      end
      tick();
      if (cyc >= 10) begin
        chk("sim_count", count, 8);
        chk("sim_ovf", overflow, 0);
      end
    end
    drain_n(8);
    chk("sim_empty", empty, 1);

    // push into empty FIFO with out_ready held high
    ob.out_ready = 1'b1;
    set_op(2, 2, 2, 2);
    exp_push(fm(2, 2, 2, 2));
    tick(); op_valid = 1'b0;
    tick(); tick(); tick();
    chk("emp_count", count, 1);
    chk("emp_data", ob.out_data, exq.pop_front());
    tick();
    chk("emp_popped", count, 0);
    ob.out_ready = 1'b0;

    // reset one edge after launch discards the result
    set_op(9, 9, 9, 9);
    tick(); op_valid = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_count", count, 0);
    end
`ifdef PIPE_COLLECT_SUM_EN
    chk("mid_sum", sum_out, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1);
  end
endmodule
